n_bit_adder_reg: RTL and testbench

// - WIDTH-bit unsigned/two's-complement adder with a registered result.
// - Carry chain built structurally from a ripple of 1-bit full adders.
// - Sum is captured into an output register on a valid input beat.
// - Used as a generic arithmetic leaf in datapaths; default width is 32.

---
 rtl/n_bit_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 16 +
 rtl/n_bit_adder_reg.sv | 79 +++++++
 tb/tb_n_bit_adder_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/n_bit_adder_pkg.sv
// Shared constants and types for the registered ripple adder.
// Optional flags (carry_out/overflow) are enabled by the ADDER_FLAGS_EN macro.
package n_bit_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Registered status produced alongside the sum when flags are enabled.
  typedef struct packed {
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the leaf cell of the ripple carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum/majority; no state.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/n_bit_adder_reg.sv
// WIDTH-bit ripple adder with a registered sum and a one-cycle valid pipe.
// Define ADDER_FLAGS_EN to add registered carry_out and signed overflow ports.
module n_bit_adder_reg
  import n_bit_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] answer,
  output logic             out_valid
`ifdef ADDER_FLAGS_EN
  ,
  output logic             carry_out,
  output logic             overflow
`endif
);

  // Carry chain: c[0] is the tied-off carry-in, c[WIDTH] leaves the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // valid pipe: [0] is the incoming beat, [1] the registered result valid.
  logic [1:0] vld_pipe;

  assign c[0]        = 1'b0;
  assign vld_pipe[0] = in_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (input1[i]),
      .b    (input2[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  // Capture the sum on a valid beat; valid itself follows in_valid every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      answer      <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) answer <= s;
    end
  end

  assign out_valid = vld_pipe[1];

`ifdef ADDER_FLAGS_EN
  flags_t flags_d, flags_q;

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    flags_d.carry = c[WIDTH];
    flags_d.ovf   = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                    (s[WIDTH-1] != input1[WIDTH-1]);
  end

  // Flags share the answer's enable so they always describe the held sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           flags_q <= '0;
    else if (vld_pipe[0]) flags_q <= flags_d;
  end

  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.ovf;
`else
  // Carry out of the MSB is intentionally dropped in the plain build.
  logic unused_carry;
  assign unused_carry = c[WIDTH];
`endif

endmodule

// File: tb/tb_n_bit_adder_reg.sv
// Self-checking bench for n_bit_adder_reg at WIDTH=32 and WIDTH=8.
// Honours ADDER_FLAGS_EN to also check carry_out/overflow.
module tb_n_bit_adder_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv32 = 1'b0, iv8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] ans32;
  logic [7:0]  ans8;
  logic        ov32, ov8;
`ifdef ADDER_FLAGS_EN
  logic        co32, co8, of32, of8;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  n_bit_adder_reg #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .input1(a32), .input2(b32),
    .answer(ans32), .out_valid(ov32)
`ifdef ADDER_FLAGS_EN
    , .carry_out(co32), .overflow(of32)
`endif
  );

  n_bit_adder_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .input1(a8), .input2(b8),
    .answer(ans8), .out_valid(ov8)
`ifdef ADDER_FLAGS_EN
    , .carry_out(co8), .overflow(of8)
`endif
  );

  // Reference: unbounded arithmetic, then reduce to w bits.
  function automatic longint unsigned ref_sum(longint unsigned a, longint unsigned b, int w);
    return (a + b) & ((64'd1 << w) - 1);
  endfunction

  function automatic bit ref_carry(longint unsigned a, longint unsigned b, int w);
    return ((a + b) >> w) != 0;
  endfunction

  // Interpret operands as signed, add, and see if the result leaves the range.
  function automatic bit ref_ovf(longint unsigned a, longint unsigned b, int w);
    longint sa, sb, ss, half;
    half = longint'(64'd1 << (w - 1));
    sa = (a >= longint'(half)) ? longint'(a) - 2 * half : longint'(a);
    sb = (b >= longint'(half)) ? longint'(b) - 2 * half : longint'(b);
    ss = sa + sb;
    return (ss > half - 1) || (ss < -half);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if (ans32 !== 32'd0 || ov32 !== 1'b0) begin
      failures++;
      $display("FAIL reset32: answer=%h out_valid=%b, required 0/0", ans32, ov32);
    end
    checks++;
    if (ans8 !== 8'd0 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8: answer=%h out_valid=%b, required 0/0", ans8, ov8);
    end
`ifdef ADDER_FLAGS_EN
    checks++;
    if (co32 !== 1'b0 || of32 !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: carry=%b ovf=%b, required 0/0", co32, of32);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    a32 = 32'd120; b32 = 32'd340; iv32 = 1'b1;
    step();
    checks++;
    if (ans32 !== 32'd460 || ov32 !== 1'b1) begin
      failures++;
      $display("FAIL basic: answer=%0d out_valid=%b, required 460/1", ans32, ov32);
    end
  endtask

  task automatic test_wrap;
    a32 = 32'hFFFF_FFFF; b32 = 32'd1; iv32 = 1'b1;
    step();
    checks++;
    if (ans32 !== 32'd0 || ov32 !== 1'b1) begin
      failures++;
      $display("FAIL wrap: answer=%h out_valid=%b, required 0/1", ans32, ov32);
    end
`ifdef ADDER_FLAGS_EN
    checks++;
    if (co32 !== 1'b1 || of32 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_flags: carry=%b ovf=%b, required 1/0", co32, of32);
    end
`endif
  endtask

  task automatic test_signed_ovf;
    a32 = 32'h7FFF_FFFF; b32 = 32'd1; iv32 = 1'b1;
    step();
    checks++;
    if (ans32 !== 32'h8000_0000) begin
      failures++;
      $display("FAIL signed_ovf: answer=%h, required 80000000", ans32);
    end
`ifdef ADDER_FLAGS_EN
    checks++;
    if (co32 !== 1'b0 || of32 !== 1'b1) begin
      failures++;
      $display("FAIL signed_ovf_flags: carry=%b ovf=%b, required 0/1", co32, of32);
    end
`endif
  endtask

  task automatic test_hold;
    a32 = 32'd5; b32 = 32'd7; iv32 = 1'b1;
    step();
    checks++;
    if (ans32 !== 32'd12 || ov32 !== 1'b1) begin
      failures++;
      $display("FAIL hold_load: answer=%0d out_valid=%b, required 12/1", ans32, ov32);
    end
    a32 = 32'd9; b32 = 32'd9; iv32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ans32 !== 32'd12 || ov32 !== 1'b0) begin
        failures++;
        $display("FAIL hold_idle%0d: answer=%0d out_valid=%b, required 12/0", i, ans32, ov32);
      end
    end
  endtask

  task automatic test_async_reset;
    a32 = 32'd1000; b32 = 32'd24; iv32 = 1'b1;
    step();
    checks++;
    if (ans32 !== 32'd1024 || ov32 !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: answer=%0d out_valid=%b, required 1024/1", ans32, ov32);
    end
    iv32 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ans32 !== 32'd0 || ov32 !== 1'b0) begin
      failures++;
      $display("FAIL areset_now: answer=%h out_valid=%b, required 0/0", ans32, ov32);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (ans32 !== 32'd0 || ov32 !== 1'b0) begin
      failures++;
      $display("FAIL areset_release: answer=%h out_valid=%b, required 0/0", ans32, ov32);
    end
  endtask

  task automatic test_random;
    longint unsigned pa32, pb32, pa8, pb8;
    for (int i = 0; i <= 1000; i++) begin
      if (i < 1000) begin
        if (i % 97 == 0) begin
          pa32 = 64'hFFFF_FFFF; pb32 = longint'($urandom_range(0, 3));
          pa8  = 64'hFF;        pb8  = longint'($urandom_range(0, 3));
        end else begin
          pa32 = longint'($urandom); pb32 = longint'($urandom);
          pa8  = longint'($urandom_range(0, 255)); pb8 = longint'($urandom_range(0, 255));
        end
        a32 = pa32[31:0]; b32 = pb32[31:0]; a8 = pa8[7:0]; b8 = pb8[7:0];
        iv32 = 1'b1; iv8 = 1'b1;
      end else begin
        iv32 = 1'b0; iv8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      end
      step();
      if (i < 1000) begin
        checks++;
        if (ans32 !== 32'(ref_sum(pa32, pb32, 32)) || ov32 !== 1'b1) begin
          failures++;
          $display("FAIL rand32[%0d]: %h+%h answer=%h ov=%b, required %h/1",
                   i, pa32, pb32, ans32, ov32, ref_sum(pa32, pb32, 32));
        end
        checks++;
        if (ans8 !== 8'(ref_sum(pa8, pb8, 8)) || ov8 !== 1'b1) begin
          failures++;
          $display("FAIL rand8[%0d]: %h+%h answer=%h ov=%b, required %h/1",
                   i, pa8, pb8, ans8, ov8, ref_sum(pa8, pb8, 8));
        end
`ifdef ADDER_FLAGS_EN
        checks++;
        if (co32 !== ref_carry(pa32, pb32, 32) || of32 !== ref_ovf(pa32, pb32, 32) ||
            co8 !== ref_carry(pa8, pb8, 8) || of8 !== ref_ovf(pa8, pb8, 8)) begin
          failures++;
          $display("FAIL rand_flags[%0d]: c32=%b o32=%b c8=%b o8=%b, required %b %b %b %b",
                   i, co32, of32, co8, of8, ref_carry(pa32, pb32, 32), ref_ovf(pa32, pb32, 32),
                   ref_carry(pa8, pb8, 8), ref_ovf(pa8, pb8, 8));
        end
`endif
      end else begin
        checks++;
        if (ov32 !== 1'b0 || ov8 !== 1'b0) begin
          failures++;
          $display("FAIL rand_drain: out_valid32=%b out_valid8=%b, required 0/0", ov32, ov8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_signed_ovf();
    test_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
